// File: rtl/rv32i_types.sv
// Shared types for the cacheline adapters: line/beat geometry and the transmit FSM states.
package rv32i_types;

  localparam int LINE_BITS        = 256;
  localparam int BEAT_BITS        = 64;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BEAT,
    WR_RESP
  } tx_state_t;

endpackage

// File: rtl/cacheline_tx_adapter.sv
// Cache-to-bmem transmit path: issues line-fill reads and serializes a 256-bit writeback into 64-bit beats.
// Write: beats start 1 cycle after acceptance, resp 1 cycle after last beat; bmem_ready low holds the current beat.
module cacheline_tx_adapter
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic                 dfp_wr_resp,
  input  logic                 rd_line_done,
  output logic                 busy,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = $clog2(BEATS);

  tx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    line_d      = line_q;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    dfp_wr_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Victim writeback goes ahead of the fill that displaced it.
        if (dfp_write) begin
          addr_d     = {dfp_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          line_d     = dfp_wdata;
          beat_cnt_d = '0;
          state_d    = WR_BEAT;
        end else if (dfp_read) begin
          addr_d  = {dfp_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_line_done) state_d = IDLE;
      end
      WR_BEAT: begin
        bmem_write = 1'b1;
        if (bmem_ready) begin
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = WR_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      WR_RESP: begin
        dfp_wr_resp = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched copies drive bmem so dfp_* may change freely once a burst is underway.
  assign bmem_addr  = addr_q;
  assign bmem_wdata = line_q[beat_cnt_q*BEAT_BITS +: BEAT_BITS];
  assign busy       = (state_q != IDLE);

endmodule
